// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback arbiter: FSM states and the
// buffered multi-cycle writeback entry.
package regfile_pkg;

   typedef enum logic {
      NORMAL = 1'b0,
      DRAIN  = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [4:0]  reg_num;
      logic [31:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer holding multi-cycle results waiting for a
// register-file write port; head is presented combinationally.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  wb_entry_t     din,
   output wb_entry_t     head,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Full blocks a push even when a pop frees a slot in the same cycle.
   assign do_push = push && (count < CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the pipeline WB stage
// and buffered multi-cycle results, with a starvation guard on the buffer.
//
// state  | meaning
// NORMAL | WB request wins; otherwise buffer head is written
// DRAIN  | buffer starved too long: WB stalled, head forced through
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter  int STARVE_LIMIT = 4,
   parameter  int MC_DEPTH     = 2,
   localparam int CW           = $clog2(MC_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_valid,
   input  logic [4:0]    wb_reg,
   input  logic [31:0]   wb_data,
   input  logic          mc_valid,
   output logic          mc_ready,
   input  logic [4:0]    mc_reg,
   input  logic [31:0]   mc_data,
   output logic          reg_write,
   output logic [4:0]    write_reg,
   output logic [31:0]   write_data,
   output logic          pipe_stall,
   output logic [CW-1:0] mc_count
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [SW-1:0] starve;
   logic [SW-1:0] starve_nxt;
   logic          wb_req;
   logic          mc_push;
   logic          fifo_empty;
   logic          grant_wb;
   logic          grant_mc;
   wb_entry_t     head;
   wb_entry_t     mc_entry;

   assign mc_ready   = mc_count < CW'(MC_DEPTH);
   // Results for r0 are accepted from the unit but dropped here.
   assign mc_push    = mc_valid && mc_ready && (mc_reg != '0);
   assign wb_req     = wb_valid && (wb_reg != '0);
   assign fifo_empty = (mc_count == '0);
   assign pipe_stall = (state == DRAIN);
   assign mc_entry   = '{reg_num: mc_reg, data: mc_data};

   wb_fifo #(.DEPTH(MC_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (mc_push),
      .pop   (grant_mc),
      .din   (mc_entry),
      .head  (head),
      .count (mc_count)
   );

   always_comb begin
      grant_wb   = 1'b0;
      grant_mc   = 1'b0;
      state_nxt  = state;
      starve_nxt = starve;
      if (!rst) begin
         unique case (state)
            DRAIN: begin
               if (!fifo_empty) begin
                  grant_mc   = 1'b1;
                  starve_nxt = '0;
                  state_nxt  = NORMAL;
               end
            end
            default: begin
               if (wb_req) begin
                  grant_wb = 1'b1;
                  if (!fifo_empty) begin
                     starve_nxt = starve + 1'b1;
                     if (starve_nxt == SW'(STARVE_LIMIT)) state_nxt = DRAIN;
                  end
               end else if (!fifo_empty) begin
                  grant_mc   = 1'b1;
                  starve_nxt = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= NORMAL;
         starve <= '0;
      end else begin
         state  <= state_nxt;
         starve <= starve_nxt;
      end
   end

   assign reg_write  = grant_wb || grant_mc;
   assign write_reg  = grant_wb ? wb_reg  : (grant_mc ? head.reg_num : '0);
   assign write_data = grant_wb ? wb_data : (grant_mc ? head.data    : '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model
// predicts each cycle's write; a monitor compares the DUT against it.
module tb_regfile_wb_arbiter;

   localparam int LIMIT = 4;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        mc_valid;
   logic        mc_ready;
   logic [4:0]  mc_reg;
   logic [31:0] mc_data;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        pipe_stall;
   logic [1:0]  mc_count;

   regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .MC_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .wb_valid   (wb_valid),
      .wb_reg     (wb_reg),
      .wb_data    (wb_data),
      .mc_valid   (mc_valid),
      .mc_ready   (mc_ready),
      .mc_reg     (mc_reg),
      .mc_data    (mc_data),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .pipe_stall (pipe_stall),
      .mc_count   (mc_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   wr_t m_q[$];
   int  m_starve = 0;
   bit  m_drain  = 1'b0;
   bit  m_acc    = 1'b0;
   int  errors   = 0;
   int  checks   = 0;
   wr_t mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_starve = 0;
      m_drain  = 1'b0;
   endtask

   // Reference model: evaluated once per cycle with the inputs of that cycle.
   task automatic step();
      bit  ready;
      bit  wbreq;
      bit  pop;
      bit  gv;
      wr_t g;
      ready = (m_q.size() < DEPTH);
      check("mc_ready", 64'(mc_ready), 64'(ready));
      check("mc_count", 64'(mc_count), 64'(m_q.size()));
      check("pipe_stall", 64'(pipe_stall), 64'(m_drain));
      wbreq = wb_valid && (wb_reg != 0);
      gv  = 1'b0;
      pop = 1'b0;
      g   = '{5'd0, 32'd0};
      if (m_drain) begin
         pop = (m_q.size() > 0);
      end else if (wbreq) begin
         gv = 1'b1;
         g  = '{wb_reg, wb_data};
         if (m_q.size() > 0) m_starve++;
      end else begin
         pop = (m_q.size() > 0);
      end
      if (pop) begin
         gv       = 1'b1;
         g        = m_q.pop_front();
         m_starve = 0;
         m_drain  = 1'b0;
      end else if (m_starve >= LIMIT) begin
         m_drain = 1'b1;
      end
      if (gv) exp_q.push_back(g);
      m_acc = mc_valid && ready;
      if (m_acc && mc_reg != 0) m_q.push_back('{mc_reg, mc_data});
   endtask

   // Called at posedge+1; leaves at the next posedge+1.
   task automatic cyc(input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                      input bit mv, input logic [4:0] mr, input logic [31:0] md);
      wb_valid = wv;
      wb_reg   = wr;
      wb_data  = wd;
      mc_valid = mv;
      mc_reg   = mr;
      mc_data  = md;
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #1;
         check("reg_write", 64'(reg_write), 64'(exp_q.size() > 0));
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (reg_write) begin
               check("write_reg", 64'(write_reg), 64'(mon_e.r));
               check("write_data", 64'(write_data), 64'(mon_e.d));
            end
         end
      end
   end

   bit          offer;
   logic [4:0]  o_r;
   logic [31:0] o_d;

   initial begin
      rst      = 1'b1;
      wb_valid = 1'b1;
      wb_reg   = 5'd5;
      wb_data  = 32'h1111_2222;
      mc_valid = 1'b1;
      mc_reg   = 5'd3;
      mc_data  = 32'h3333_4444;
      #12;
      check("rst_reg_write", 64'(reg_write), 64'd0);
      check("rst_pipe_stall", 64'(pipe_stall), 64'd0);
      check("rst_mc_count", 64'(mc_count), 64'd0);
      check("rst_mc_ready", 64'(mc_ready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      // WB write with empty buffer
      cyc(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
      // single mc result, WB idle
      cyc(0, 5'd0, 32'd0, 1, 5'd7, 32'h12);
      cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      // starvation: r3 buffered, WB busy for 6 cycles
      cyc(0, 5'd0, 32'd0, 1, 5'd3, 32'h0000_0333);
      for (int i = 0; i < 6; i++) cyc(1, 5'd9, 32'h900 + 32'(i), 0, 5'd0, 32'd0);
      cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      // buffer fills with WB busy; third offer held until space
      cyc(1, 5'd9, 32'hA0, 1, 5'd10, 32'hA);
      cyc(1, 5'd9, 32'hA1, 1, 5'd11, 32'hB);
      for (int i = 0; i < 5; i++) cyc(1, 5'd9, 32'hA2 + 32'(i), 1, 5'd12, 32'hC);
      for (int i = 0; i < 4; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      // r0 on both sources
      cyc(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
      cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      // fill buffer, reach DRAIN, then reset mid-operation
      cyc(1, 5'd9, 32'hB0, 1, 5'd13, 32'hD);
      cyc(1, 5'd9, 32'hB1, 1, 5'd14, 32'hE);
      for (int i = 0; i < 3; i++) cyc(1, 5'd9, 32'hB2 + 32'(i), 0, 5'd0, 32'd0);
      check("pre_rst_pipe_stall", 64'(pipe_stall), 64'(m_drain));
      check("pre_rst_mc_count", 64'(mc_count), 64'(m_q.size()));
      rst = 1'b1;
      #1;
      check("async_rst_mc_count", 64'(mc_count), 64'd0);
      check("async_rst_pipe_stall", 64'(pipe_stall), 64'd0);
      check("async_rst_reg_write", 64'(reg_write), 64'd0);
      check("async_rst_mc_ready", 64'(mc_ready), 64'd1);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

      // random traffic; an mc offer is held until accepted
      offer = 1'b0;
      o_r   = 5'd0;
      o_d   = 32'd0;
      for (int i = 0; i < 400; i++) begin
         if (!offer && $urandom_range(0, 2) != 0) begin
            offer = 1'b1;
            o_r   = 5'($urandom_range(0, 31));
            o_d   = $urandom;
         end
         cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             offer, o_r, o_d);
         if (m_acc) offer = 1'b0;
      end
      for (int i = 0; i < 8; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      check("final_mc_count", 64'(mc_count), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive lost-arbitration cycles before the FIFO head is forced through.
REQ-002 SHALL have parameter MC_DEPTH, default 2, meaning the number of multi-cycle writeback buffer entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wb_valid, input, 1 bit: the pipeline WB stage requests a register write.
REQ-006 SHALL have port wb_reg, input, 5 bits: the pipeline destination register.
REQ-007 SHALL have port wb_data, input, 32 bits: the pipeline write data.
REQ-008 SHALL have port mc_valid, input, 1 bit: the multi-cycle (mult/div) unit offers a result.
REQ-009 SHALL have port mc_ready, output, 1 bit: the arbiter accepts the mc result this cycle.
REQ-010 SHALL have port mc_reg, input, 5 bits: the mc destination register.
REQ-011 SHALL have port mc_data, input, 32 bits: the mc result.
REQ-012 SHALL have port reg_write, output, 1 bit: the register-file write enable.
REQ-013 SHALL have port write_reg, output, 5 bits: the register-file write address.
REQ-014 SHALL have port write_data, output, 32 bits: the register-file write data.
REQ-015 SHALL have port pipe_stall, output, 1 bit: the pipeline must hold WB; the WB request is not served this cycle.
REQ-016 SHALL have port mc_count, output, clog2(MC_DEPTH+1) bits: the current FIFO occupancy.

Function
REQ-017 SHALL define mc_ready = (mc_count < MC_DEPTH) combinationally; no push is allowed when full, even if a pop occurs in the same cycle.
REQ-018 SHALL treat an mc_valid&&mc_ready handshake as an accept; an accept with mc_reg==0 is consumed and discarded, never enqueued.
REQ-019 SHALL treat wb_valid with wb_reg==0 as no request.
REQ-020 SHALL drive reg_write/write_reg/write_data combinationally from the granted source (the register file samples them on negedge), and drive all zeros when there is no grant.
REQ-021 SHALL use FSM states NORMAL and DRAIN, with pipe_stall=1 exactly while in DRAIN.
REQ-022 SHALL grant in NORMAL as follows: a valid WB request wins; otherwise a non-empty FIFO head wins and is popped.
REQ-023 SHALL grant the FIFO head in DRAIN, ignoring WB.
REQ-024 SHALL increment the starve counter in NORMAL when the FIFO is non-empty and WB wins.
REQ-025 SHALL clear the starve counter on any pop.
REQ-026 SHALL transition NORMAL->DRAIN at the posedge where the counter reaches STARVE_LIMIT.
REQ-027 SHALL transition DRAIN->NORMAL after exactly one pop, clearing the counter.
REQ-028 SHALL handle an enqueue into an empty FIFO with WB idle as follows: the entry is written on the following cycle, so the minimum mc latency is accept->write in 1 cycle.
REQ-029 SHALL allow a simultaneous push and pop (count < MC_DEPTH): the count is unchanged and order is preserved.
REQ-030 SHALL write entries in strict FIFO order; wrap-around of the read/write pointers is invisible to the outputs.
REQ-031 SHALL honour a pop from the FIFO head granted in the same cycle a new entry arrives; the new entry never bypasses the FIFO.

Reset
REQ-032 SHALL, while rst is high, empty the FIFO, set the counter to 0 and set the state to NORMAL, giving reg_write=0, pipe_stall=0, mc_count=0 and mc_ready=1.
REQ-033 SHALL, on reset asserted mid-operation, discard all buffered entries without any write; no write is issued while rst=1.

Structure
REQ-034 SHALL place the state enum (NORMAL, DRAIN) and the wb-entry struct {reg[4:0], data[31:0]} in the shared package regfile_pkg.
REQ-035 SHALL implement the buffer as the sub-module wb_fifo (parameterised depth, push/pop/count).

Verification
REQ-036 SHALL cover: wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF with FIFO empty -> reg_write=1, write_reg=5, same cycle.
REQ-037 SHALL cover: mc accept reg=7, data=0x12 with WB idle -> write of r7=0x12 the next cycle, mc_count returning 1->0.
REQ-038 SHALL cover: FIFO holding r3, with wb_valid=1 (reg 9) for 6 cycles -> r9 written on cycles 1-4, DRAIN on cycle 5 (pipe_stall=1, r3 written), NORMAL on cycle 6.
REQ-039 SHALL cover: two mc accepts back-to-back with WB busy -> mc_count=2, mc_ready=0, and the third mc_valid is held off until a pop.
REQ-040 SHALL cover: mc accept with reg=0 and wb_reg=0 valid -> no reg_write, mc_count stays 0.
REQ-041 SHALL cover: rst asserted asynchronously with mc_count=2 in DRAIN -> immediately mc_count=0, pipe_stall=0, and no write of the buffered data afterward.
